// File: rtl/ethernet_system_descriptor_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : ethernet_system_descriptor_fetcher
// Purpose  : Avalon-MM master that walks a linked chain of 4-word descriptors
//            in the descriptor RAM. It hands each owned descriptor to the DMA
//            engine over a valid/ready handshake and waits for the completion
//            report. It then writes back status and clears the OWN bit before
//            following the next pointer.
// Ports    : clk_i/reset_n_i       - clock, synchronous active-low reset
//            start_i/head_ptr_i    - begin a walk at head_ptr (low 2 bits -> 0)
//            stop_i                - halt at the next descriptor boundary
//            busy_o/chain_end_o    - walk in progress / ended on OWN=0
//            m_*                   - Avalon-MM master (1-cycle read latency)
//            desc_*                - descriptor presented to the DMA
//            cmpl_*                - completion report from the DMA
//            irq_o/irq_clear_i     - only with DESC_FETCH_IRQ_EN defined
// Option   : `define DESC_FETCH_IRQ_EN adds the irq_o/irq_clear_i interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module ethernet_system_descriptor_fetcher #(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] head_ptr_i,
    input  logic              stop_i,
    output logic              busy_o,
    output logic              chain_end_o,
    output logic [ADDR_W-1:0] m_address_o,
    output logic              m_chipselect_o,
    output logic              m_write_o,
    output logic [3:0]        m_byteenable_o,
    output logic [31:0]       m_writedata_o,
    input  logic [31:0]       m_readdata_i,
    output logic              desc_valid_o,
    input  logic              desc_ready_i,
    output logic [31:0]       desc_buf_addr_o,
    output logic [LEN_W-1:0]  desc_length_o,
    output logic              desc_eop_o,
    input  logic              cmpl_valid_i,
    input  logic [LEN_W-1:0]  cmpl_length_i,
    input  logic              cmpl_error_i
`ifdef DESC_FETCH_IRQ_EN
    ,
    output logic              irq_o,
    input  logic              irq_clear_i
`endif
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD0     = 4'd1,
        S_RD1     = 4'd2,
        S_RD2     = 4'd3,
        S_RD3     = 4'd4,
        S_CHECK   = 4'd5,
        S_PRESENT = 4'd6,
        S_WAIT    = 4'd7,
        S_WB_STS  = 4'd8,
        S_WB_OWN  = 4'd9,
        S_NEXT    = 4'd10
    } state_t;

    localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ~ADDR_W'(3);

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;      // base address P of the current descriptor
    logic [ADDR_W-1:0] next_q;     // next pointer, already word-aligned
    logic              own_q;
    logic [5:0]        w1_hi_q;    // word1[29:24], preserved by the OWN clear
    logic              err_q;      // latched cmpl_error, feeds the irq

    // P+k wraps naturally at ADDR_W bits
    logic [ADDR_W-1:0] ptr_p1, ptr_p2, ptr_p3;
    assign ptr_p1 = ptr_q + ADDR_W'(1);
    assign ptr_p2 = ptr_q + ADDR_W'(2);
    assign ptr_p3 = ptr_q + ADDR_W'(3);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            next_q          <= '0;
            own_q           <= 1'b0;
            w1_hi_q         <= '0;
            err_q           <= 1'b0;
            busy_o          <= 1'b0;
            chain_end_o     <= 1'b0;
            m_address_o     <= '0;
            m_chipselect_o  <= 1'b0;
            m_write_o       <= 1'b0;
            m_byteenable_o  <= 4'hF;
            m_writedata_o   <= '0;
            desc_valid_o    <= 1'b0;
            desc_buf_addr_o <= '0;
            desc_length_o   <= '0;
            desc_eop_o      <= 1'b0;
        end else begin
            chain_end_o <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        ptr_q          <= head_ptr_i & C_ALIGN_MASK;
                        m_address_o    <= head_ptr_i & C_ALIGN_MASK;
                        m_chipselect_o <= 1'b1;
                        busy_o         <= 1'b1;
                        state_q        <= S_RD0;
                    end
                end
                S_RD0: begin
                    m_address_o <= ptr_p1;
                    state_q     <= S_RD1;
                end
                S_RD1: begin
                    desc_buf_addr_o <= m_readdata_i;
                    m_address_o     <= ptr_p2;
                    state_q         <= S_RD2;
                end
                S_RD2: begin
                    own_q          <= m_readdata_i[31];
                    desc_eop_o     <= m_readdata_i[30];
                    w1_hi_q        <= m_readdata_i[29:24];
                    desc_length_o  <= m_readdata_i[LEN_W-1:0];
                    m_chipselect_o <= 1'b0;
                    state_q        <= S_RD3;
                end
                S_RD3: begin
                    next_q  <= m_readdata_i[ADDR_W-1:0] & C_ALIGN_MASK;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (!own_q) begin
                        chain_end_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else if (stop_i) begin
                        busy_o  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        desc_valid_o <= 1'b1;
                        state_q      <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (desc_ready_i) begin
                        desc_valid_o <= 1'b0;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cmpl_valid_i) begin
                        err_q          <= cmpl_error_i;
                        m_address_o    <= ptr_p3;
                        m_chipselect_o <= 1'b1;
                        m_write_o      <= 1'b1;
                        m_byteenable_o <= 4'hF;
                        m_writedata_o  <= {cmpl_error_i, 1'b1,
                                           {(30-LEN_W){1'b0}}, cmpl_length_i};
                        state_q        <= S_WB_STS;
                    end
                end
                S_WB_STS: begin
                    // Top byte only: OWN cleared, EOP and bits [29:24] kept
                    m_address_o    <= ptr_p1;
                    m_byteenable_o <= 4'b1000;
                    m_writedata_o  <= {1'b0, desc_eop_o, w1_hi_q, 24'h0};
                    state_q        <= S_WB_OWN;
                end
                S_WB_OWN: begin
                    m_chipselect_o <= 1'b0;
                    m_write_o      <= 1'b0;
                    m_byteenable_o <= 4'hF;
                    ptr_q          <= next_q;
                    state_q        <= S_NEXT;
                end
                S_NEXT: begin
                    if (stop_i) begin
                        busy_o  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        m_address_o    <= ptr_q;
                        m_chipselect_o <= 1'b1;
                        state_q        <= S_RD0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DESC_FETCH_IRQ_EN
    // Set wins over a simultaneous clear
    logic irq_set;
    assign irq_set = ((state_q == S_WB_OWN) && (desc_eop_o || err_q)) ||
                     ((state_q == S_CHECK) && !own_q);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            irq_o <= 1'b0;
        end else if (irq_set) begin
            irq_o <= 1'b1;
        end else if (irq_clear_i) begin
            irq_o <= 1'b0;
        end
    end
`else
    // No interrupt logic in this build; err_q only matters for the irq.
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule
`default_nettype wire
